usb_uart_rx: RTL and testbench
==============================

# usb_uart_rx

Serial-to-byte receiver on the downstream side of the CDC bridge core. It consumes the core's UART-style serial output (`rx_o`, 8N1, idle high, `BAUDRATE`) in the 60 MHz ULPI clock domain. It deserialises the frames and buffers the received bytes in a small first-word-fall-through FIFO. Downstream logic pulls bytes over a valid/accept handshake, so host-to-device CDC traffic becomes a byte stream instead of a looped-back serial line.

## Interface
Parameters:
- `CLK_FREQ`, 60000000: frequency of `clk_i` in Hz.
- `BAUDRATE`, 1000000: bit rate of `rx_i`. `DIV = CLK_FREQ/BAUDRATE` must be an integer ≥ 4; default is 60.
- `FIFO_DEPTH`, 16: byte buffer depth. Must be a power of two, ≥ 2.

Ports:
- `clk_i`, in, 1: single clock; this is the ULPI-derived USB clock.
- `rst_i`, in, 1: asynchronous, active-low reset.
- `rx_i`, in, 1: serial line from the CDC core `rx_o`; idle high.
- `data_o`, out, 8: head-of-FIFO byte; valid only while `valid_o` is high.
- `valid_o`, out, 1: FIFO non-empty.
- `accept_i`, in, 1: pops the head byte when sampled high together with `valid_o`.
- `level_o`, out, clog2(FIFO_DEPTH)+1: FIFO occupancy.
- `framing_err_o`, out, 1: one-cycle pulse when the stop bit is sampled low.
- `overflow_o`, out, 1: one-cycle pulse when a good byte is dropped because the FIFO is full.

## Operation
- `rx_i` passes through a 2-flop synchronizer; its reset value is 1. All decisions use the synchronized value `rx_s`.
- Bit counter `div_cnt` is clog2(DIV) bits wide. Bit index `bit_cnt` is 4 bits. The shift register fills LSB first.
- State `IDLE`:
  - Arms only after `rx_s`=1 has been seen since reset or since the last `BREAK`.
  - `rx_s`=0 while armed loads `div_cnt`=DIV/2−1 and moves to `START`.
- State `START`:
  - On `div_cnt`=0, sample `rx_s`.
  - If 1, it was a glitch: go to `IDLE` with no pulse.
  - If 0, reload DIV−1, clear `bit_cnt`, go to `DATA`.
- State `DATA`:
  - On each `div_cnt`=0, shift `rx_s` in and reload DIV−1.
  - After the 8th sample, go to `STOP`.
- State `STOP`:
  - On `div_cnt`=0, sample `rx_s`.
  - If 1: push the byte and return to `IDLE`, already armed.
  - If 0: pulse `framing_err_o`, discard the byte, go to `BREAK`.
- State `BREAK`: wait for `rx_s`=1, then go to `IDLE`, armed.
- FIFO push and pop:
  - A push while full pulses `overflow_o` and drops the byte; the FIFO contents are unchanged.
  - Push and pop in the same cycle while full: the pop frees the slot and the push succeeds, with no overflow and `level_o` unchanged.
  - Push and pop in the same cycle while empty: not possible, because `valid_o` is 0 and no pop occurs.
  - `accept_i` while `valid_o`=0 is ignored.
- Pointers are clog2(FIFO_DEPTH)+1 bits and wrap naturally. Full and empty are derived from the MSB and the address compare.
- Reset mid-frame clears all state immediately:
  - FIFO empty; state `IDLE`, disarmed.
  - The partial byte is lost.
  - A line still low after reset release does not start a frame.
- Reset values: `data_o`=0x00, `valid_o`=0, `level_o`=0, `framing_err_o`=0, `overflow_o`=0.

## Timing
- Cycle 0 is the first clock edge at which `rx_i` is low at a start bit.
  - `rx_s` goes low at cycle 2.
  - Mid-start sample at cycle 2+DIV/2.
  - Data bit k sampled at cycle 2+DIV/2+(k+1)·DIV.
  - Stop sample at cycle 2+DIV/2+9·DIV; this is 572 at the default DIV.
- `valid_o` and `data_o` update 1 cycle after a successful stop sample; this is 573 at the default DIV.
- A pop takes effect at the accepting edge. The next byte appears on `data_o` in the same cycle that `level_o` decrements.
- `framing_err_o` and `overflow_o` assert for exactly 1 cycle, coincident with the stop-sample edge + 1.
- Back-to-back frames with zero idle time are received without loss; stop sampling ends DIV/2 before the next start edge.
- Tolerated baud mismatch is at least ±3 %.

## Structure
- Shared package `usb_uart_pkg`:
  - state enum `IDLE`/`START`/`DATA`/`STOP`/`BREAK`;
  - function computing `DIV` and its width;
  - 8N1 frame constants (data bits = 8, stop level = 1).
- One natural sub-module: `usb_uart_rx_fifo`, the parameterised FWFT byte FIFO with `level_o`. The receiver FSM stays in the top module.

## Test plan
- Send 0x55 then 0xA5 at exactly DIV=60 → `valid_o` rises at cycle 573 with `data_o`=0x55; after accept, 0xA5; `level_o` goes 1, 2, then 1, 0.
- 20-cycle low glitch on idle line → no byte pushed, no `framing_err_o`, state returns to `IDLE`.
- Frame 0x3C with stop bit forced low, line held low 200 cycles, then 0x81 → one `framing_err_o` pulse, only 0x81 received.
- 17 frames with `accept_i`=0, FIFO_DEPTH=16 → `level_o`=16 and one `overflow_o` pulse on the 17th. Repeat with `accept_i` asserted on the 17th push cycle → no overflow, `level_o` stays 16.
- `rst_i` asserted mid-data-bit 4 while the line stays low 100 cycles after release → all outputs at reset values, no spurious byte; next clean 0xF0 received correctly.
- Baud skewed +3 % and −3 % on random bytes, back-to-back with no idle → all bytes match, no errors.

Source files
------------

// File: rtl/usb_uart_pkg.sv
// Shared types and constants for the USB-side UART receiver.
// Holds the receiver state encoding, divisor helpers and 8N1 frame constants.
package usb_uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_e;

  localparam int unsigned DATA_BITS  = 8;
  localparam logic        STOP_LEVEL = 1'b1;

  // Clock cycles per serial bit
  function automatic int unsigned calc_div(input int unsigned clk_freq,
                                           input int unsigned baud);
    return clk_freq / baud;
  endfunction

  // Width of the bit-period down-counter
  function automatic int unsigned calc_div_w(input int unsigned clk_freq,
                                             input int unsigned baud);
    return $clog2(calc_div(clk_freq, baud));
  endfunction

endpackage

// File: rtl/usb_uart_rx_fifo.sv
// First-word-fall-through byte FIFO with occupancy count.
// A push into a full FIFO is dropped and flagged unless a pop frees the slot in the same cycle.
module usb_uart_rx_fifo #(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [7:0]               push_data_i,
  input  logic                     pop_i,
  output logic [7:0]               data_o,
  output logic                     valid_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     overflow_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_level;
  logic [7:0]    r_mem [DEPTH];
  logic          r_valid;
  logic          r_overflow;

  logic          w_full;
  logic          w_empty;
  logic          w_pop;
  logic          w_wr;
  logic          w_ovf;
  logic [PW-1:0] w_level_nxt;

  assign w_full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_empty     = (r_wr_ptr == r_rd_ptr);
  assign w_pop       = pop_i & ~w_empty;
  assign w_wr        = push_i & (~w_full | w_pop);
  assign w_ovf       = push_i & w_full & ~w_pop;
  assign w_level_nxt = r_level + PW'(w_wr) - PW'(w_pop);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_valid    <= 1'b0;
      r_overflow <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_wr) begin
        r_mem[r_wr_ptr[AW-1:0]] <= push_data_i;
        r_wr_ptr                <= r_wr_ptr + PW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      r_level    <= w_level_nxt;
      r_valid    <= (w_level_nxt != '0);
      r_overflow <= w_ovf;
    end
  end

  assign data_o     = r_mem[r_rd_ptr[AW-1:0]];
  assign valid_o    = r_valid;
  assign level_o    = r_level;
  assign overflow_o = r_overflow;

endmodule

// File: rtl/usb_uart_rx.sv
// 8N1 serial receiver feeding a FWFT byte FIFO with a valid/accept pop port.
// Frames are sampled mid-bit from a two-flop synchronised copy of the line.
module usb_uart_rx
  import usb_uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 60000000,
  parameter int unsigned BAUDRATE   = 1000000,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          rx_i,
  output logic [7:0]                    data_o,
  output logic                          valid_o,
  input  logic                          accept_i,
  output logic [$clog2(FIFO_DEPTH):0]   level_o,
  output logic                          framing_err_o,
  output logic                          overflow_o
);

  localparam int unsigned DIV = calc_div(CLK_FREQ, BAUDRATE);
  localparam int unsigned DW  = calc_div_w(CLK_FREQ, BAUDRATE);
  localparam logic [DW-1:0] CNT_HALF = DW'(DIV / 2 - 1);
  localparam logic [DW-1:0] CNT_FULL = DW'(DIV - 1);

  rx_state_e     r_state;
  rx_state_e     w_state_nxt;
  logic          r_sync1;
  logic          r_rx_s;
  logic [1:0]    r_settle;
  logic [DW-1:0] r_div_cnt;
  logic [3:0]    r_bit_cnt;
  logic [7:0]    r_shift;
  logic          r_armed;
  logic          r_push;
  logic          r_ferr;

  logic          w_tick;
  logic          w_cnt_load;
  logic [DW-1:0] w_cnt_val;
  logic          w_bit_clr;
  logic          w_shift_en;
  logic          w_push;
  logic          w_ferr;
  logic          w_arm_set;
  logic          w_arm_clr;

  assign w_tick = (r_div_cnt == '0);

  // Synchroniser resets high so an idle line is not seen as a start bit
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_sync1 <= 1'b1;
      r_rx_s  <= 1'b1;
    end else begin
      r_sync1 <= rx_i;
      r_rx_s  <= r_sync1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:  if (r_armed && !r_rx_s) w_state_nxt = START;
      START: if (w_tick) w_state_nxt = r_rx_s ? IDLE : DATA;
      DATA:  if (w_tick && (r_bit_cnt == 4'(DATA_BITS - 1))) w_state_nxt = STOP;
      STOP:  if (w_tick) w_state_nxt = (r_rx_s == STOP_LEVEL) ? IDLE : BREAK;
      BREAK: if (r_rx_s) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_cnt_load = 1'b0;
    w_cnt_val  = CNT_FULL;
    w_bit_clr  = 1'b0;
    w_shift_en = 1'b0;
    w_push     = 1'b0;
    w_ferr     = 1'b0;
    w_arm_set  = 1'b0;
    w_arm_clr  = 1'b0;
    case (r_state)
      IDLE: begin
        // Arm only once the synchroniser holds real line samples
        if (!r_armed && r_rx_s && (r_settle == 2'd2)) w_arm_set = 1'b1;
        if (r_armed && !r_rx_s) begin
          w_cnt_load = 1'b1;
          w_cnt_val  = CNT_HALF;
        end
      end
      START: if (w_tick && !r_rx_s) begin
        w_cnt_load = 1'b1;
        w_bit_clr  = 1'b1;
      end
      DATA: if (w_tick) begin
        w_shift_en = 1'b1;
        w_cnt_load = 1'b1;
      end
      STOP: if (w_tick) begin
        if (r_rx_s == STOP_LEVEL) begin
          w_push = 1'b1;
        end else begin
          w_ferr    = 1'b1;
          w_arm_clr = 1'b1;
        end
      end
      BREAK: if (r_rx_s) w_arm_set = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_settle      <= '0;
      r_div_cnt     <= '0;
      r_bit_cnt     <= '0;
      r_shift       <= '0;
      r_armed       <= 1'b0;
      r_push        <= 1'b0;
      r_ferr        <= 1'b0;
      framing_err_o <= 1'b0;
    end else begin
      if (r_settle != 2'd2) r_settle <= r_settle + 2'd1;
      if (w_cnt_load)          r_div_cnt <= w_cnt_val;
      else if (!w_tick)        r_div_cnt <= r_div_cnt - DW'(1);
      if (w_bit_clr)           r_bit_cnt <= '0;
      else if (w_shift_en)     r_bit_cnt <= r_bit_cnt + 4'd1;
      if (w_shift_en)          r_shift   <= {r_rx_s, r_shift[7:1]};
      if (w_arm_set)           r_armed   <= 1'b1;
      else if (w_arm_clr)      r_armed   <= 1'b0;
      r_push        <= w_push;
      r_ferr        <= w_ferr;
      framing_err_o <= r_ferr;
    end
  end

  usb_uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (r_push),
    .push_data_i (r_shift),
    .pop_i       (accept_i),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .level_o     (level_o),
    .overflow_o  (overflow_o)
  );

endmodule

// File: tb/tb_usb_uart_rx.sv
// Directed bench for usb_uart_rx at the default 60 MHz / 1 Mbaud / 16-deep configuration.
`timescale 1ns/1ps
module tb_usb_uart_rx;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       rx_i;
  logic [7:0] data_o;
  logic       valid_o;
  logic       accept_i;
  logic [4:0] level_o;
  logic       framing_err_o;
  logic       overflow_o;

  int errors = 0;
  int checks = 0;
  int ferr_cnt = 0;
  int ovf_cnt = 0;
  int base_f;
  int base_o;
  logic [7:0] pat [17];
  logic [7:0] rnd [8];
  realtime    bt;

  usb_uart_rx dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .rx_i          (rx_i),
    .data_o        (data_o),
    .valid_o       (valid_o),
    .accept_i      (accept_i),
    .level_o       (level_o),
    .framing_err_o (framing_err_o),
    .overflow_o    (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  // Pulse counters: one count per cycle the flag is high
  always @(negedge clk_i) begin
    if (rst_i === 1'b1 && framing_err_o === 1'b1) ferr_cnt++;
    if (rst_i === 1'b1 && overflow_o === 1'b1) ovf_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input realtime bit_t, input logic stop);
    rx_i = 1'b0;
    #(bit_t);
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      #(bit_t);
    end
    rx_i = stop;
    #(bit_t);
  endtask

  task automatic pop_check(input string tag, input logic [7:0] exp);
    check({tag, "_valid"}, 32'(valid_o), 32'd1);
    check({tag, "_data"}, 32'(data_o), 32'(exp));
    accept_i = 1'b1;
    wait_cyc(1);
    accept_i = 1'b0;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "timeout");
  end

  initial begin
    for (int k = 0; k < 17; k++) pat[k] = 8'(k * 13 + 1);
    rst_i = 1'b0; rx_i = 1'b1; accept_i = 1'b0;
    #2;
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_level", 32'(level_o), 32'd0);
    check("rst_data",  32'(data_o),  32'd0);
    check("rst_ferr",  32'(framing_err_o), 32'd0);
    check("rst_ovf",   32'(overflow_o), 32'd0);
    wait_cyc(3);
    rst_i = 1'b1;
    wait_cyc(10);

    // Latency and ordering: 0x55 then 0xA5 back to back
    fork
      begin
        send_byte(8'h55, 600.0, 1'b1);
        send_byte(8'hA5, 600.0, 1'b1);
      end
      begin
        wait_cyc(573);
        check("lat_valid_c572", 32'(valid_o), 32'd0);
        wait_cyc(1);
        check("lat_valid_c573", 32'(valid_o), 32'd1);
        check("lat_data_c573",  32'(data_o),  32'h55);
        check("lat_level_c573", 32'(level_o), 32'd1);
      end
    join
    wait_cyc(20);
    check("two_level", 32'(level_o), 32'd2);
    pop_check("pop55", 8'h55);
    check("after_pop1_level", 32'(level_o), 32'd1);
    pop_check("popA5", 8'hA5);
    check("after_pop2_level", 32'(level_o), 32'd0);
    check("after_pop2_valid", 32'(valid_o), 32'd0);

    // Short glitch on the idle line
    base_f = ferr_cnt;
    rx_i = 1'b0; #200; rx_i = 1'b1;
    wait_cyc(200);
    check("glitch_valid", 32'(valid_o), 32'd0);
    check("glitch_ferr",  32'(ferr_cnt - base_f), 32'd0);

    // Framing error, held break, then a clean byte
    base_f = ferr_cnt;
    send_byte(8'h3C, 600.0, 1'b0);
    rx_i = 1'b0; #2000;
    rx_i = 1'b1; #1200;
    send_byte(8'h81, 600.0, 1'b1);
    wait_cyc(50);
    check("brk_ferr_pulses", 32'(ferr_cnt - base_f), 32'd1);
    check("brk_level", 32'(level_o), 32'd1);
    pop_check("brk_81", 8'h81);
    check("brk_empty", 32'(valid_o), 32'd0);

    // Seventeen frames into a 16-deep FIFO, no accept
    base_o = ovf_cnt;
    fork
      for (int k = 0; k < 17; k++) send_byte(pat[k], 600.0, 1'b1);
      begin
        wait_cyc(10173);
        check("ovf_pre_level", 32'(level_o), 32'd16);
        check("ovf_pre_flag",  32'(overflow_o), 32'd0);
        wait_cyc(1);
        check("ovf_flag", 32'(overflow_o), 32'd1);
        check("ovf_level", 32'(level_o), 32'd16);
        wait_cyc(1);
        check("ovf_flag_drop", 32'(overflow_o), 32'd0);
      end
    join
    wait_cyc(20);
    check("ovf_pulses", 32'(ovf_cnt - base_o), 32'd1);
    for (int k = 0; k < 16; k++) pop_check("ovf_drain", pat[k]);
    check("ovf_drained", 32'(valid_o), 32'd0);

    // Same again, with a pop on the 17th push cycle
    base_o = ovf_cnt;
    fork
      for (int k = 0; k < 17; k++) send_byte(pat[k], 600.0, 1'b1);
      begin
        wait_cyc(10173);
        accept_i = 1'b1;
        wait_cyc(1);
        accept_i = 1'b0;
        check("pp_flag",  32'(overflow_o), 32'd0);
        check("pp_level", 32'(level_o), 32'd16);
        check("pp_head",  32'(data_o), 32'(pat[1]));
      end
    join
    wait_cyc(20);
    check("pp_pulses", 32'(ovf_cnt - base_o), 32'd0);
    for (int k = 1; k < 17; k++) pop_check("pp_drain", pat[k]);

    // Reset during data bit 4 with the line held low afterwards
    send_byte(8'h12, 600.0, 1'b1);
    wait_cyc(20);
    check("pre_rst_level", 32'(level_o), 32'd1);
    base_f = ferr_cnt;
    rx_i = 1'b0;
    wait_cyc(302);
    rst_i = 1'b0;
    #1;
    check("mid_rst_valid", 32'(valid_o), 32'd0);
    check("mid_rst_level", 32'(level_o), 32'd0);
    check("mid_rst_data",  32'(data_o),  32'd0);
    wait_cyc(3);
    rst_i = 1'b1;
    wait_cyc(100);
    rx_i = 1'b1;
    wait_cyc(700);
    check("post_rst_valid", 32'(valid_o), 32'd0);
    check("post_rst_ferr",  32'(ferr_cnt - base_f), 32'd0);
    send_byte(8'hF0, 600.0, 1'b1);
    wait_cyc(50);
    check("post_rst_level", 32'(level_o), 32'd1);
    pop_check("post_rst_F0", 8'hF0);

    // Baud skew of +3 % and -3 %, back to back
    for (int s = 0; s < 2; s++) begin
      bt = (s == 0) ? 618.0 : 582.0;
      base_f = ferr_cnt;
      base_o = ovf_cnt;
      for (int k = 0; k < 8; k++) rnd[k] = 8'($urandom_range(0, 255));
      for (int k = 0; k < 8; k++) send_byte(rnd[k], bt, 1'b1);
      wait_cyc(100);
      check("skew_level", 32'(level_o), 32'd8);
      check("skew_ferr", 32'(ferr_cnt - base_f), 32'd0);
      check("skew_ovf",  32'(ovf_cnt - base_o), 32'd0);
      for (int k = 0; k < 8; k++) pop_check("skew_byte", rnd[k]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
